// File: rtl/axi_adc_jesd204_pack_if.sv
// Bundle of the ADC-side sample stream and the FIFO-side packed-word stream
// around axi_adc_jesd204_pack.
//   adc_valid    : adc_data/adc_enable valid this cycle
//   adc_enable   : per-channel enable, bit n gates channel n
//   adc_data     : channel n block at [(n+1)*B-1:n*B], B = 16*DATA_PATH_WIDTH
//   fifo_wr_en   : one-cycle strobe, fifo_wr_data holds a complete word
//   fifo_wr_data : packed word
//   fifo_wr_sync : first word after reset or after an enable change
//   cfg_err      : enabled-channel count is not a power of two
// master = sample source / FIFO sink side, slave = the packer.
interface axi_adc_jesd204_pack_if #(
  parameter int unsigned NUM_CHANNELS    = 4,
  parameter int unsigned DATA_PATH_WIDTH = 2
);
  localparam int unsigned W = NUM_CHANNELS * 16 * DATA_PATH_WIDTH;

  logic                    adc_valid;
  logic [NUM_CHANNELS-1:0] adc_enable;
  logic [W-1:0]            adc_data;
  logic                    fifo_wr_en;
  logic [W-1:0]            fifo_wr_data;
  logic                    fifo_wr_sync;
  logic                    cfg_err;

  modport master (
    output adc_valid, adc_enable, adc_data,
    input  fifo_wr_en, fifo_wr_data, fifo_wr_sync, cfg_err
  );

  modport slave (
    input  adc_valid, adc_enable, adc_data,
    output fifo_wr_en, fifo_wr_data, fifo_wr_sync, cfg_err
  );
endinterface

// File: rtl/axi_adc_jesd204_pack.sv
// Packs the enabled per-channel sample blocks into dense full-width words.
// Stage 1 compacts the enabled channels (lowest index at the LSB) and places
// the segment at its slot in the word; stage 2 merges it into the output
// word and strobes fifo_wr_en when the last slot has been written.
// Ports:
//   adc_clk : sample clock
//   adc_rst : synchronous active-high reset
//   bus     : axi_adc_jesd204_pack_if.slave (adc_* in, fifo_*/cfg_err out)
// Build option: ADC_PACK_SAMPLE_INTERLEAVE_EN orders each segment sample-major
// instead of channel-major.
module axi_adc_jesd204_pack #(
  parameter int unsigned NUM_CHANNELS    = 4,
  parameter int unsigned DATA_PATH_WIDTH = 2
) (
  input  logic                          adc_clk,
  input  logic                          adc_rst,
  axi_adc_jesd204_pack_if.slave         bus
);

  localparam int unsigned B  = 16 * DATA_PATH_WIDTH;
  localparam int unsigned W  = NUM_CHANNELS * B;
  localparam int unsigned PW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  // stage-1 / control state
  logic [PW-1:0]           phase_q, phase_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic                    sync_pend_q, sync_pend_d;
  logic                    cfg_err_q, cfg_err_d;
  logic                    seg_vld_q, seg_vld_d;
  logic                    seg_last_q, seg_last_d;
  logic                    seg_sync_q, seg_sync_d;
  logic [W-1:0]            seg_q, seg_d;
  logic [W-1:0]            seg_wmask_q, seg_wmask_d;

  // stage-2 / output state
  logic                    wr_en_q, wr_en_d;
  logic                    wr_sync_q, wr_sync_d;
  logic [W-1:0]            wr_data_q, wr_data_d;

  // stage-1 helpers
  int unsigned             en_cnt;
  int unsigned             words_per;
  int unsigned             pos;
  int unsigned             shift;
  logic                    cfg_ok;
  logic                    change;
  logic                    accept;
  logic                    last;
  logic [PW-1:0]           phase_eff;
  logic [W-1:0]            compact;
  logic [W-1:0]            ones;

  always_comb begin
    en_cnt = 0;
    for (int unsigned n = 0; n < NUM_CHANNELS; n++) begin
      en_cnt = en_cnt + {31'd0, bus.adc_enable[n]};
    end
    cfg_ok    = (en_cnt != 0) && ((en_cnt & (en_cnt - 1)) == 0);
    words_per = cfg_ok ? (NUM_CHANNELS / en_cnt) : 1;
    change    = (bus.adc_enable != mask_q);
    // A mask change restarts the word, so the current beat lands in slot 0.
    phase_eff = change ? '0 : phase_q;
    accept    = bus.adc_valid && cfg_ok;
    last      = (32'(phase_eff) == (words_per - 1));

    compact = '0;
    pos     = 0;
`ifdef ADC_PACK_SAMPLE_INTERLEAVE_EN
    for (int unsigned k = 0; k < DATA_PATH_WIDTH; k++) begin
      for (int unsigned n = 0; n < NUM_CHANNELS; n++) begin
        if (bus.adc_enable[n]) begin
          compact[pos*16 +: 16] = bus.adc_data[n*B + k*16 +: 16];
          pos = pos + 1;
        end
      end
    end
`else
    for (int unsigned n = 0; n < NUM_CHANNELS; n++) begin
      if (bus.adc_enable[n]) begin
        compact[pos*B +: B] = bus.adc_data[n*B +: B];
        pos = pos + 1;
      end
    end
`endif

    // Segment is pre-shifted into its slot so stage 2 is a plain masked merge.
    shift       = 32'(phase_eff) * en_cnt * B;
    ones        = '1;
    seg_wmask_d = (ones >> (W - en_cnt * B)) << shift;
    seg_d       = compact << shift;

    phase_d     = phase_q;
    mask_d      = mask_q;
    sync_pend_d = sync_pend_q;
    cfg_err_d   = cfg_err_q;
    seg_vld_d   = 1'b0;
    seg_last_d  = 1'b0;
    seg_sync_d  = 1'b0;

    if (bus.adc_valid) begin
      mask_d      = bus.adc_enable;
      cfg_err_d   = (en_cnt != 0) && !cfg_ok;
      sync_pend_d = sync_pend_q | change;
      if (accept) begin
        seg_vld_d  = 1'b1;
        seg_last_d = last;
        seg_sync_d = sync_pend_q | change;
        if (last) begin
          phase_d     = '0;
          sync_pend_d = 1'b0;
        end else begin
          phase_d = phase_eff + 1'b1;
        end
      end else begin
        phase_d = '0;
      end
    end
  end

  always_comb begin
    wr_en_d   = seg_vld_q & seg_last_q;
    wr_sync_d = seg_vld_q & seg_last_q & seg_sync_q;
    wr_data_d = wr_data_q;
    if (seg_vld_q) begin
      wr_data_d = (wr_data_q & ~seg_wmask_q) | seg_q;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      phase_q     <= '0;
      mask_q      <= '0;
      sync_pend_q <= 1'b1;
      cfg_err_q   <= 1'b0;
      seg_vld_q   <= 1'b0;
      seg_last_q  <= 1'b0;
      seg_sync_q  <= 1'b0;
      seg_q       <= '0;
      seg_wmask_q <= '0;
      wr_en_q     <= 1'b0;
      wr_sync_q   <= 1'b0;
      wr_data_q   <= '0;
    end else begin
      phase_q     <= phase_d;
      mask_q      <= mask_d;
      sync_pend_q <= sync_pend_d;
      cfg_err_q   <= cfg_err_d;
      seg_vld_q   <= seg_vld_d;
      seg_last_q  <= seg_last_d;
      seg_sync_q  <= seg_sync_d;
      seg_q       <= seg_d;
      seg_wmask_q <= seg_wmask_d;
      wr_en_q     <= wr_en_d;
      wr_sync_q   <= wr_sync_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_wr_sync = wr_sync_q;
  assign bus.fifo_wr_data = wr_data_q;
  assign bus.cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_axi_adc_jesd204_pack.sv
// Bench for axi_adc_jesd204_pack (4 channels, 2 samples per channel).
module tb_axi_adc_jesd204_pack;
  localparam int unsigned N   = 4;
  localparam int unsigned DPW = 2;
  localparam int unsigned B   = 32;
  localparam int unsigned W   = 128;

  logic adc_clk = 1'b0;
  logic adc_rst = 1'b1;

  axi_adc_jesd204_pack_if #(.NUM_CHANNELS(N), .DATA_PATH_WIDTH(DPW)) bus ();

  axi_adc_jesd204_pack #(.NUM_CHANNELS(N), .DATA_PATH_WIDTH(DPW)) dut (
    .adc_clk (adc_clk),
    .adc_rst (adc_rst),
    .bus     (bus)
  );

  always #5 adc_clk = ~adc_clk;

  int tests = 0;
  int fails = 0;
  int m     = 0;
  int words_seen = 0;
  logic [W-1:0] last_word;
  logic         last_sync;

  typedef struct {
    logic [W-1:0] data;
    logic         sync;
    int           due;
  } exp_t;
  exp_t q[$];

  // reference state
  logic [N-1:0] m_mask;
  logic         m_sync;
  logic         m_cfg;
  int           m_cnt;
  logic [W-1:0] m_word;

  function automatic logic [W-1:0] build_seg(input logic [N-1:0] en, input logic [W-1:0] d);
    logic [15:0]  s[$];
    logic [W-1:0] r;
    r = '0;
`ifdef ADC_PACK_SAMPLE_INTERLEAVE_EN
    for (int k = 0; k < DPW; k++)
      for (int n = 0; n < N; n++)
        if (en[n]) s.push_back(d[n*B + k*16 +: 16]);
`else
    for (int n = 0; n < N; n++)
      if (en[n])
        for (int k = 0; k < DPW; k++) s.push_back(d[n*B + k*16 +: 16]);
`endif
    foreach (s[i]) r[i*16 +: 16] = s[i];
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_mask = '0; m_sync = 1'b1; m_cfg = 1'b0; m_cnt = 0; m_word = '0;
  endtask

  task automatic check_cycle();
    exp_t e;
    logic ok;
    tests++;
    if (bus.fifo_wr_en === 1'b1) begin
      words_seen++;
      last_word = bus.fifo_wr_data;
      last_sync = bus.fifo_wr_sync;
    end
    if (q.size() > 0 && q[0].due == m) begin
      e  = q.pop_front();
      ok = (bus.fifo_wr_en === 1'b1) && (bus.fifo_wr_sync === e.sync) &&
           (bus.fifo_wr_data === e.data) && (bus.cfg_err === m_cfg);
      if (!ok) begin
        fails++;
        $display("FAIL model cyc=%0d: got en=%b sync=%b cfg=%b data=%h, want en=1 sync=%b cfg=%b data=%h",
                 m, bus.fifo_wr_en, bus.fifo_wr_sync, bus.cfg_err, bus.fifo_wr_data, e.sync, m_cfg, e.data);
      end
    end else begin
      ok = (bus.fifo_wr_en === 1'b0) && (bus.fifo_wr_sync === 1'b0) && (bus.cfg_err === m_cfg);
      if (!ok) begin
        fails++;
        $display("FAIL model cyc=%0d: got en=%b sync=%b cfg=%b, want en=0 sync=0 cfg=%b",
                 m, bus.fifo_wr_en, bus.fifo_wr_sync, bus.cfg_err, m_cfg);
      end
    end
  endtask

  // Drive one cycle of inputs (sampled at the next rising edge) and advance the model.
  task automatic step(input logic rst, input logic v, input logic [N-1:0] en, input logic [W-1:0] d);
    int e_cnt;
    exp_t x;
    adc_rst        = rst;
    bus.adc_valid  = v;
    bus.adc_enable = en;
    bus.adc_data   = d;
    if (rst) begin
      model_reset();
    end else if (v) begin
      e_cnt = $countones(en);
      if (en != m_mask) begin
        m_cnt = 0; m_word = '0; m_sync = 1'b1;
      end
      m_mask = en;
      m_cfg  = (e_cnt != 0) && ((e_cnt & (e_cnt - 1)) != 0);
      if (e_cnt != 0 && !m_cfg) begin
        m_word = m_word | (build_seg(en, d) << (m_cnt * e_cnt * 16 * DPW));
        m_cnt++;
        if (m_cnt == N / e_cnt) begin
          x.data = m_word; x.sync = m_sync; x.due = m + 2;
          q.push_back(x);
          m_sync = 1'b0; m_cnt = 0; m_word = '0;
        end
      end
    end
  endtask

  task automatic tick(input logic rst, input logic v, input logic [N-1:0] en, input logic [W-1:0] d);
    @(negedge adc_clk);
    m++;
    check_cycle();
    step(rst, v, en, d);
  endtask

  task automatic expect_eq(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  typedef struct {
    logic         rst;
    logic         v;
    logic [N-1:0] en;
    logic [W-1:0] d;
    logic         e_en;
    logic         e_sync;
    logic         e_cfg;
    logic         chk_d;
    logic [W-1:0] e_d;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [W-1:0] D, D2, DO, D2O, WD;
    logic [W-1:0] a[4], c[4], d1[4], dd, w0, nw;
    int base;

    D  = 128'h0003_1003_0002_1002_0001_1001_0000_1000;
    D2 = 128'h0013_1013_0012_1012_0011_1011_0010_1010;
`ifdef ADC_PACK_SAMPLE_INTERLEAVE_EN
    DO  = 128'h0003_0002_0001_0000_1003_1002_1001_1000;
    D2O = 128'h0013_0012_0011_0010_1013_1012_1011_1010;
    WD  = 128'h0011_0010_1011_1010_0001_0000_1001_1000;
`else
    DO  = D;
    D2O = D2;
    WD  = 128'h0011_1011_0010_1010_0001_1001_0000_1000;
`endif
    //            rst  v    en     d   e_en e_sync e_cfg chk  e_d
    tbl[0]  = '{1'b0, 1'b1, 4'hF, D,  1'b0, 1'b0, 1'b0, 1'b1, '0};
    tbl[1]  = '{1'b0, 1'b1, 4'hF, D2, 1'b0, 1'b0, 1'b0, 1'b1, '0};
    tbl[2]  = '{1'b0, 1'b0, 4'hF, '0, 1'b1, 1'b1, 1'b0, 1'b1, DO};
    tbl[3]  = '{1'b0, 1'b0, 4'hF, '0, 1'b1, 1'b0, 1'b0, 1'b1, D2O};
    tbl[4]  = '{1'b0, 1'b0, 4'hF, '0, 1'b0, 1'b0, 1'b0, 1'b1, D2O};
    tbl[5]  = '{1'b0, 1'b1, 4'h7, D,  1'b0, 1'b0, 1'b0, 1'b1, D2O};
    tbl[6]  = '{1'b0, 1'b0, 4'h7, '0, 1'b0, 1'b0, 1'b1, 1'b1, D2O};
    tbl[7]  = '{1'b0, 1'b1, 4'h3, D,  1'b0, 1'b0, 1'b1, 1'b1, D2O};
    tbl[8]  = '{1'b0, 1'b1, 4'h3, D2, 1'b0, 1'b0, 1'b0, 1'b1, D2O};
    tbl[9]  = '{1'b0, 1'b0, 4'h3, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0};
    tbl[10] = '{1'b0, 1'b0, 4'h3, '0, 1'b1, 1'b1, 1'b0, 1'b1, WD};
    tbl[11] = '{1'b0, 1'b0, 4'h3, '0, 1'b0, 1'b0, 1'b0, 1'b1, WD};

    bus.adc_valid = 1'b0; bus.adc_enable = '0; bus.adc_data = '0;
    model_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0, '0);

    // directed table
    for (int i = 0; i < 12; i++) begin
      @(negedge adc_clk);
      m++;
      check_cycle();
      tests++;
      if (bus.fifo_wr_en !== tbl[i].e_en || bus.fifo_wr_sync !== tbl[i].e_sync ||
          bus.cfg_err !== tbl[i].e_cfg || (tbl[i].chk_d && bus.fifo_wr_data !== tbl[i].e_d)) begin
        fails++;
        $display("FAIL table row %0d: got en=%b sync=%b cfg=%b data=%h, want en=%b sync=%b cfg=%b data=%h",
                 i, bus.fifo_wr_en, bus.fifo_wr_sync, bus.cfg_err, bus.fifo_wr_data,
                 tbl[i].e_en, tbl[i].e_sync, tbl[i].e_cfg, tbl[i].e_d);
      end
      step(tbl[i].rst, tbl[i].v, tbl[i].en, tbl[i].d);
    end

    // enable 0101: four beats, two words
    base = words_seen;
    for (int i = 0; i < 4; i++) begin
      a[i] = {96'd0, $urandom}; c[i] = {96'd0, $urandom};
      tick(1'b0, 1'b1, 4'b0101, (c[i] << 64) | a[i]);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 4'b0101, '0);
    expect_eq("ch02_word_count", W'(words_seen - base), W'(2));
`ifdef ADC_PACK_SAMPLE_INTERLEAVE_EN
    w0 = {c[3][31:16], a[3][31:16], c[3][15:0], a[3][15:0],
          c[2][31:16], a[2][31:16], c[2][15:0], a[2][15:0]};
`else
    w0 = {c[3][31:0], a[3][31:0], c[2][31:0], a[2][31:0]};
`endif
    expect_eq("ch02_second_word", last_word, w0);

    // enable 0010 with gappy valid pattern 1,0,1,1,0,1
    base = words_seen;
    begin
      logic pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      int j = 0;
      for (int i = 0; i < 6; i++) begin
        dd = rnd_data();
        if (pat[i]) begin d1[j] = {96'd0, dd[63:32]}; j++; end
        tick(1'b0, pat[i], 4'b0010, dd);
      end
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 4'b0010, '0);
    expect_eq("ch1_word_count", W'(words_seen - base), W'(1));
    expect_eq("ch1_word", last_word, {d1[3][31:0], d1[2][31:0], d1[1][31:0], d1[0][31:0]});

    // enable change 0011 -> 1111 after one beat: partial word dropped
    base = words_seen;
    tick(1'b0, 1'b1, 4'b0011, rnd_data());
    nw = rnd_data();
    tick(1'b0, 1'b1, 4'b1111, nw);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 4'b1111, '0);
    expect_eq("chg_word_count", W'(words_seen - base), W'(1));
    expect_eq("chg_word", last_word, build_seg(4'b1111, nw));
    expect_eq("chg_sync", W'(last_sync), W'(1));

    // non power-of-two enable for 20 cycles, then recover
    base = words_seen;
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 4'b0111, rnd_data());
    expect_eq("bad_cfg_err", W'(bus.cfg_err), W'(1));
    expect_eq("bad_no_words", W'(words_seen - base), W'(0));
    tick(1'b0, 1'b1, 4'b0011, rnd_data());
    tick(1'b0, 1'b1, 4'b0011, rnd_data());
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 4'b0011, '0);
    expect_eq("recover_words", W'(words_seen - base), W'(1));
    expect_eq("recover_sync", W'(last_sync), W'(1));

    // reset mid-word with a single channel
    tick(1'b0, 1'b1, 4'b0001, rnd_data());
    tick(1'b0, 1'b1, 4'b0001, rnd_data());
    tick(1'b1, 1'b0, 4'b0001, '0);
    tick(1'b0, 1'b0, 4'b0001, '0);
    expect_eq("rst_outputs", {bus.fifo_wr_data, 3'b0} | W'({bus.fifo_wr_en, bus.fifo_wr_sync, bus.cfg_err}), '0);
    base = words_seen;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 4'b0001, rnd_data());
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 4'b0001, '0);
    expect_eq("rst_partial_none", W'(words_seen - base), W'(0));
    tick(1'b0, 1'b1, 4'b0001, rnd_data());
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 4'b0001, '0);
    expect_eq("rst_word_count", W'(words_seen - base), W'(1));
    expect_eq("rst_word_sync", W'(last_sync), W'(1));

    // randomized traffic against the reference model
    begin
      logic [N-1:0] ren;
      ren = 4'b1111;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 19) == 0) ren = N'($urandom_range(0, 15));
        tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), ren, rnd_data());
      end
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, bus.adc_enable, '0);
    expect_eq("drain_empty", W'(q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
